// File: rtl/keypad_emulator_pkg.sv
// Shared types for the keypad emulator: key codes, key position, and FSM states.
package keypad_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_P,
    HOLD,
    BOUNCE_R,
    GAP
  } emu_state_t;

  function automatic key_pos_t code_to_pos(input logic [3:0] code);
    key_pos_t p;
    p = '0;
    case (code)
      KEY_1: p = '{row: 2'd0, col: 2'd0};
      KEY_2: p = '{row: 2'd0, col: 2'd1};
      KEY_3: p = '{row: 2'd0, col: 2'd2};
      KEY_A: p = '{row: 2'd0, col: 2'd3};
      KEY_4: p = '{row: 2'd1, col: 2'd0};
      KEY_5: p = '{row: 2'd1, col: 2'd1};
      KEY_6: p = '{row: 2'd1, col: 2'd2};
      KEY_B: p = '{row: 2'd1, col: 2'd3};
      KEY_7: p = '{row: 2'd2, col: 2'd0};
      KEY_8: p = '{row: 2'd2, col: 2'd1};
      KEY_9: p = '{row: 2'd2, col: 2'd2};
      KEY_C: p = '{row: 2'd2, col: 2'd3};
      KEY_D: p = '{row: 2'd3, col: 2'd0};
      KEY_0: p = '{row: 2'd3, col: 2'd1};
      KEY_E: p = '{row: 2'd3, col: 2'd2};
      KEY_F: p = '{row: 2'd3, col: 2'd3};
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Key-press command channel: valid/ready request with key code, plus busy/done status.
interface keypad_emulator_if;
  logic       press_valid;
  logic       press_ready;
  logic [3:0] key_code;
  logic       busy;
  logic       done;

  modport master (output press_valid, output key_code,
                  input press_ready, input busy, input done);
  modport slave  (input press_valid, input key_code,
                  output press_ready, output busy, output done);
endinterface

// File: rtl/keypad_emulator_bounce_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11) supplying contact bounce bits.
module bounce_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic n_reset,
  input  logic step,
  output logic bit_out
);

  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign bit_out = lfsr[0];

endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad model: holds one key per command and answers the column scan.
// Contact bounce on press/release is enabled by defining KEYPAD_EMU_BOUNCE_EN.
//
// state    | meaning
// IDLE     | open contact, ready for a command
// BOUNCE_P | press bounce, contact follows the LFSR
// HOLD     | clean closed contact
// BOUNCE_R | release bounce, contact follows the LFSR
// GAP      | forced open time before the next command
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int          BOUNCE_CYCLES = 2000,
  parameter int          BOUNCE_STEP   = 64,
  parameter int          HOLD_CYCLES   = 540000,
  parameter int          GAP_CYCLES    = 270000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [3:0]        columnas,
  output logic [3:0]        filas,
  keypad_emulator_if.slave  cmd
);

  localparam int MAX_P = max_int(max_int(BOUNCE_CYCLES, BOUNCE_STEP),
                                 max_int(HOLD_CYCLES, GAP_CYCLES));
  localparam int CW = $clog2(MAX_P) + 1;

  if (BOUNCE_STEP < 1) begin : g_bad_step
    $error("BOUNCE_STEP must be at least 1");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end

  emu_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          contact, contact_nxt;
  logic          done_q, done_nxt;
  logic [3:0]    key_q;
  logic          accept;
  key_pos_t      pos;

  assign accept          = cmd.press_valid && (state == IDLE);
  assign cmd.press_ready = (state == IDLE);
  assign cmd.busy        = (state != IDLE);
  assign cmd.done        = done_q;
  assign pos             = code_to_pos(key_q);

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [CW-1:0] step_cnt;
  logic          step_hit;
  logic          lfsr_bit;
  logic          lfsr_step;

  assign step_hit = (step_cnt == CW'(BOUNCE_STEP - 1));

  bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .n_reset (n_reset),
    .step    (lfsr_step),
    .bit_out (lfsr_bit)
  );

  // Step counter restarts on every state change so each bounce phase starts aligned.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      step_cnt <= '0;
    end else if ((state_nxt != state) || step_hit) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + CW'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      contact <= 1'b0;
      done_q  <= 1'b0;
      key_q   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= ((state_nxt != state) || (state == IDLE)) ? '0 : cnt + CW'(1);
      contact <= contact_nxt;
      done_q  <= done_nxt;
      if (accept) begin
        key_q <= cmd.key_code;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    contact_nxt = contact;
    done_nxt    = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
    lfsr_step   = 1'b0;
`endif
    case (state)
      IDLE: begin
        contact_nxt = 1'b0;
        if (accept) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_nxt   = BOUNCE_P;
          contact_nxt = 1'b0;
`else
          state_nxt   = HOLD;
          contact_nxt = 1'b1;
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      BOUNCE_P: begin
        if (cnt == CW'(BOUNCE_CYCLES - 1)) begin
          state_nxt   = HOLD;
          contact_nxt = 1'b1;
        end else if (step_hit) begin
          contact_nxt = lfsr_bit;
          lfsr_step   = 1'b1;
        end
      end
      BOUNCE_R: begin
        if (cnt == CW'(BOUNCE_CYCLES - 1)) begin
          state_nxt   = GAP;
          contact_nxt = 1'b0;
        end else if (step_hit) begin
          contact_nxt = lfsr_bit;
          lfsr_step   = 1'b1;
        end
      end
`endif
      HOLD: begin
        contact_nxt = 1'b1;
        if (cnt == CW'(HOLD_CYCLES - 1)) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_nxt = BOUNCE_R;
`else
          state_nxt = GAP;
`endif
          contact_nxt = 1'b0;
        end
      end
      GAP: begin
        contact_nxt = 1'b0;
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        contact_nxt = 1'b0;
      end
    endcase
  end

  // Row bit 3-r is ~r for a 2-bit index; same for columns.
  always_comb begin
    filas = '0;
    if (contact && columnas[~pos.col]) begin
      filas[~pos.row] = 1'b1;
    end
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Synthesizable model of the 4x4 membrane keypad: the passive end of the column-scan/row-sense matrix.
- Accepts key-press commands through a valid/ready handshake.
- While a key is held, drives its row line whenever the scanner energises that key's column.
- Press and release edges include LFSR-driven contact bounce, so the scanner/debounce path can be exercised on the board or in the bench without a physical keypad.

Parameters:
- BOUNCE_CYCLES, 2000: length of each bounce phase (press and release), in clk cycles.
- BOUNCE_STEP, 64: cycles between contact re-evaluations during a bounce phase; must be ≥1.
- HOLD_CYCLES, 540000: clean closed-contact time (20 ms @ 27 MHz).
- GAP_CYCLES, 270000: forced open time after release, before the next command is accepted.
- LFSR_SEED, 16'hACE1: bounce LFSR reset value; must be non-zero.

Ports:
- clk, in, 1: system clock.
- n_reset, in, 1: asynchronous active-low reset.
- columnas, in, 4: one-hot active-high column drive from the scanner. Bit 3 = column 0, bit 0 = column 3.
- filas, out, 4: row sense lines to the scanner, active-high. Bit 3 = row 0, bit 0 = row 3.
- press_valid, in, 1: command request.
- press_ready, out, 1: high only in IDLE.
- key_code, in, 4: key to press; sampled on handshake.
- busy, out, 1: high from acceptance until GAP ends.
- done, out, 1: one-cycle pulse on the GAP→IDLE transition.

Behaviour:
- Key map, code→(row,col):
  - 1→(0,0), 2→(0,1), 3→(0,2), A→(0,3)
  - 4→(1,0), 5→(1,1), 6→(1,2), B→(1,3)
  - 7→(2,0), 8→(2,1), 9→(2,2), C→(2,3)
  - D→(3,0), 0→(3,1), E→(3,2), F→(3,3)
- filas is combinational:
  - filas[3-row] = contact & columnas[3-col]; all other bits 0.
  - Multi-hot columnas lights the row if the key's column bit is set.
  - This is the only combinational path.
- Reset state: state=IDLE, contact=0, counters=0, LFSR=LFSR_SEED, key latch=0.
  - Resulting outputs: filas=0, press_ready=1, busy=0, done=0.
- Handshake:
  - Transfer happens when press_valid & press_ready on a rising edge; key_code is latched that cycle.
  - press_valid while not ready is ignored (not queued).
  - The requester holds key_code stable while valid.
- FSM (one counter, cleared on every transition):
  - IDLE: contact=0. Handshake → BOUNCE_P.
  - BOUNCE_P: every BOUNCE_STEP cycles, contact ← LFSR[0] and the LFSR advances (x^16+x^14+x^13+x^11). After BOUNCE_CYCLES → HOLD.
  - HOLD: contact=1. After HOLD_CYCLES → BOUNCE_R.
  - BOUNCE_R: same as BOUNCE_P. After BOUNCE_CYCLES → GAP.
  - GAP: contact=0. After GAP_CYCLES → IDLE, with done=1 for that cycle.
- Bounce step timing:
  - The step counter restarts on entry to each bounce phase.
  - The first contact update occurs BOUNCE_STEP cycles after entry; contact is 0 until then.
- Latency:
  - First possible filas assertion: BOUNCE_STEP+1 cycles after the handshake.
  - Guaranteed assertion: HOLD entry + 0, while the column is active.
  - Total busy time: 2·BOUNCE_CYCLES + HOLD_CYCLES + GAP_CYCLES cycles.
- Counter widths: $clog2 of the largest parameter + 1. Comparisons use count == P-1.
- Reset mid-operation: contact drops immediately (async), filas=0, FSM→IDLE, the command is lost, and no done pulse is produced.
- The LFSR is not reset between commands; the bounce pattern varies per press and is deterministic from reset.

Optional Feature:
- KEYPAD_EMU_BOUNCE_EN.
- Defined: bounce phases behave as described above.
- Undefined:
  - BOUNCE_P and BOUNCE_R are bypassed (IDLE→HOLD, HOLD→GAP).
  - Contact edges are clean and the LFSR is not instantiated.
  - Latency from handshake to contact=1 is exactly 1 cycle.
  - Busy time is HOLD_CYCLES + GAP_CYCLES.

Decomposition:
- keypad_pkg:
  - localparams KEY_0…KEY_F (4-bit codes).
  - typedef key_pos_t {logic [1:0] row; logic [1:0] col;}.
  - function code_to_pos(code) implementing the map above.
  - typedef enum emu_state_t {IDLE, BOUNCE_P, HOLD, BOUNCE_R, GAP}.
- Sub-module bounce_lfsr (16-bit Galois LFSR):
  - Ports: clk, n_reset, step, bit_out; SEED parameter.
  - Instantiated only under KEYPAD_EMU_BOUNCE_EN.

Test Plan (bench params BOUNCE_CYCLES=8, BOUNCE_STEP=1, HOLD_CYCLES=32, GAP_CYCLES=16):
- Reset, then idle → filas=0, press_ready=1, busy=0; columnas toggling all patterns produces filas=0.
- Press code 5, columnas=4'b0100 held → in HOLD filas=4'b0100 for all 32 cycles; columnas=4'b1000 gives filas=0; done pulses exactly 2·8+32+16=64 cycles after handshake.
- Sweep all 16 codes with columnas rotating one-hot → each HOLD shows the single (row,col) from the map. Code 0 → filas=4'b0001 only when columnas=4'b0100; code F → filas=4'b0001 only when columnas=4'b0001.
- press_valid asserted during busy with code 3 → ignored; after done, the next accepted code is the one present at the new handshake.
- Assert n_reset=0 in HOLD of code A → filas=0 that cycle, busy=0, no done; after release press_ready=1.
- KEYPAD_EMU_BOUNCE_EN undefined, press 9 → contact=1 one cycle after handshake, no toggles, busy exactly 48 cycles. Defined → at least one contact 0/1 toggle in BOUNCE_P with seed ACE1.
